// File: rtl/controller.sv
// Decode/condition unit for the single-cycle ARM-subset datapath; NZCV flags are held here.
// Define CONTROLLER_CMP_EN to decode cmd 1010 with S=1 as CMP (subtract, set flags, no write).
module controller (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr,
  input  logic [3:0]  ALUFlags,
  output logic [1:0]  RegSrc,
  output logic        RegWrite,
  output logic [1:0]  ImmSrc,
  output logic        ALUSrc,
  output logic [1:0]  ALUControl,
  output logic        MemWrite,
  output logic        MemtoReg,
  output logic        PCSrc
);

  typedef struct packed {
    logic       branch;
    logic       mem_to_reg;
    logic       mem_w;
    logic       alu_src;
    logic [1:0] imm_src;
    logic       reg_w;
    logic [1:0] reg_src;
    logic       alu_op;
  } main_dec_t;

  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic [3:0] cmd;
  logic       s_bit;

  main_dec_t  md;
  logic [1:0] alu_ctl;
  logic [1:0] flag_w;
  logic       no_write;
  logic       reg_w;
  logic       pcs;
  logic       cond_ex;

  logic [1:0] nz_q;
  logic [1:0] cv_q;
  logic       n, z, c, v;

  assign cond  = Instr[31:28];
  assign op    = Instr[27:26];
  assign funct = Instr[25:20];
  assign rd    = Instr[15:12];
  assign cmd   = funct[4:1];
  assign s_bit = funct[0];

  logic unused_instr;
  assign unused_instr = ^{Instr[19:16], Instr[11:0]};

  // Main decode; unused encodings drive all zeros.
  always_comb begin
    md = '0;
    unique case (op)
      2'b00: begin
        md.alu_src = funct[5];
        md.reg_w   = 1'b1;
        md.alu_op  = 1'b1;
      end
      2'b01: begin
        md.alu_src = 1'b1;
        md.imm_src = 2'b01;
        if (funct[0]) begin
          md.mem_to_reg = 1'b1;
          md.reg_w      = 1'b1;
        end else begin
          md.mem_w   = 1'b1;
          md.reg_src = 2'b10;
        end
      end
      2'b10: begin
        md.branch  = 1'b1;
        md.alu_src = 1'b1;
        md.imm_src = 2'b10;
        md.reg_src = 2'b01;
      end
      default: md = '0;
    endcase
  end

  // ALU decode; unsupported commands fall back to ADD without touching flags.
  always_comb begin
    alu_ctl  = 2'b00;
    flag_w   = 2'b00;
    no_write = 1'b0;
    if (md.alu_op) begin
      case (cmd)
        4'b0100: begin alu_ctl = 2'b00; flag_w = {s_bit, s_bit}; end
        4'b0010: begin alu_ctl = 2'b01; flag_w = {s_bit, s_bit}; end
        4'b0000: begin alu_ctl = 2'b10; flag_w = {s_bit, 1'b0};  end
        4'b1100: begin alu_ctl = 2'b11; flag_w = {s_bit, 1'b0};  end
`ifdef CONTROLLER_CMP_EN
        4'b1010: begin
          if (s_bit) begin
            alu_ctl  = 2'b01;
            flag_w   = 2'b11;
            no_write = 1'b1;
          end
        end
`endif
        default: begin alu_ctl = 2'b00; flag_w = 2'b00; end
      endcase
    end
  end

  assign reg_w = md.reg_w & ~no_write;
  assign pcs   = md.branch | (reg_w & (rd == 4'hF));

  assign n = nz_q[1];
  assign z = nz_q[0];
  assign c = cv_q[1];
  assign v = cv_q[0];

  always_comb begin
    cond_ex = 1'b0;
    unique case (cond)
      4'h0: cond_ex = z;
      4'h1: cond_ex = ~z;
      4'h2: cond_ex = c;
      4'h3: cond_ex = ~c;
      4'h4: cond_ex = n;
      4'h5: cond_ex = ~n;
      4'h6: cond_ex = v;
      4'h7: cond_ex = ~v;
      4'h8: cond_ex = c & ~z;
      4'h9: cond_ex = ~c | z;
      4'hA: cond_ex = (n == v);
      4'hB: cond_ex = (n != v);
      4'hC: cond_ex = ~z & (n == v);
      4'hD: cond_ex = z | (n != v);
      4'hE: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  // Condition uses the flags before this edge; new values appear next cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      nz_q <= 2'b00;
      cv_q <= 2'b00;
    end else begin
      if (flag_w[1] & cond_ex) nz_q <= ALUFlags[3:2];
      if (flag_w[0] & cond_ex) cv_q <= ALUFlags[1:0];
    end
  end

  assign RegSrc     = md.reg_src;
  assign ImmSrc     = md.imm_src;
  assign ALUSrc     = md.alu_src;
  assign ALUControl = alu_ctl;
  assign MemtoReg   = md.mem_to_reg;
  assign RegWrite   = reg_w & cond_ex;
  assign MemWrite   = md.mem_w & cond_ex;
  assign PCSrc      = pcs & cond_ex;

endmodule

// File: tb/tb_controller.sv
// Scoreboard bench for controller: directed ARM encodings then randomized instructions
// against an instruction-level reference model with its own NZCV copy.
module tb_controller;
  logic        clk;
  logic        reset;
  logic [31:0] Instr;
  logic [3:0]  ALUFlags;
  logic [1:0]  RegSrc;
  logic        RegWrite;
  logic [1:0]  ImmSrc;
  logic        ALUSrc;
  logic [1:0]  ALUControl;
  logic        MemWrite;
  logic        MemtoReg;
  logic        PCSrc;

  controller dut (
    .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
    .RegSrc(RegSrc), .RegWrite(RegWrite), .ImmSrc(ImmSrc), .ALUSrc(ALUSrc),
    .ALUControl(ALUControl), .MemWrite(MemWrite), .MemtoReg(MemtoReg), .PCSrc(PCSrc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ins;
    logic [10:0] exp;
  } sb_t;

  sb_t        sbq[$];
  int         n_vec = 0;
  int         n_err = 0;
  logic [3:0] mflags;  // model copy of {N,Z,C,V}

  // Reference: outputs packed as {RegSrc,RegWrite,ImmSrc,ALUSrc,ALUControl,MemWrite,MemtoReg,PCSrc};
  // fw returns the effective flag writes {NZ,CV} for this instruction.
  function automatic logic [10:0] model(input logic [31:0] ins, input logic [3:0] f,
                                         output logic [1:0] fw);
    logic [3:0] cnd, cmd, rd;
    logic [1:0] op, rs, imm, aluc;
    logic s, pass, isb, regw, memw, m2r, asrc, arith, known;
    logic fn, fz, fc, fv;
    cnd = ins[31:28]; op = ins[27:26]; cmd = ins[24:21]; s = ins[20]; rd = ins[15:12];
    {fn, fz, fc, fv} = f;
    case (cnd)
      4'h0: pass = fz;          4'h1: pass = !fz;
      4'h2: pass = fc;          4'h3: pass = !fc;
      4'h4: pass = fn;          4'h5: pass = !fn;
      4'h6: pass = fv;          4'h7: pass = !fv;
      4'h8: pass = fc && !fz;   4'h9: pass = !fc || fz;
      4'hA: pass = fn == fv;    4'hB: pass = fn != fv;
      4'hC: pass = !fz && (fn == fv);
      4'hD: pass = fz || (fn != fv);
      4'hE: pass = 1'b1;
      default: pass = 1'b0;
    endcase
    rs = 2'b00; imm = 2'b00; aluc = 2'b00; fw = 2'b00;
    isb = 0; regw = 0; memw = 0; m2r = 0; asrc = 0;
    if (op == 2'b00) begin
      regw = 1; asrc = ins[25];
      known = 1; arith = 0;
      case (cmd)
        4'd4:  begin aluc = 2'b00; arith = 1; end
        4'd2:  begin aluc = 2'b01; arith = 1; end
        4'd0:  aluc = 2'b10;
        4'd12: aluc = 2'b11;
        default: known = 0;
      endcase
      if (known) fw = {s, s & arith};
`ifdef CONTROLLER_CMP_EN
      if (cmd == 4'd10 && s) begin aluc = 2'b01; fw = 2'b11; regw = 0; end
`endif
    end else if (op == 2'b01) begin
      asrc = 1; imm = 2'b01;
      if (ins[20]) begin regw = 1; m2r = 1; end
      else begin memw = 1; rs = 2'b10; end
    end else if (op == 2'b10) begin
      isb = 1; asrc = 1; imm = 2'b10; rs = 2'b01;
    end
    if (!pass) fw = 2'b00;
    return {rs, regw & pass, imm, asrc, aluc, memw & pass, m2r,
            (isb || (regw && rd == 4'hF)) && pass};
  endfunction

  // Drive one instruction after an edge, post its expectation, then cross the next edge.
  task automatic apply(input logic [31:0] ins, input logic [3:0] af);
    logic [1:0] fw;
    sb_t        e;
    Instr = ins; ALUFlags = af;
    e.ins = ins;
    e.exp = model(ins, mflags, fw);
    sbq.push_back(e);
    @(posedge clk);
    if (reset) begin
      if (fw[1]) mflags[3:2] = af[3:2];
      if (fw[0]) mflags[1:0] = af[1:0];
    end
    #1;
  endtask

  always @(negedge clk) begin
    sb_t        e;
    logic [10:0] got;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      got = {RegSrc, RegWrite, ImmSrc, ALUSrc, ALUControl, MemWrite, MemtoReg, PCSrc};
      n_vec++;
      if (got !== e.exp) begin
        n_err++;
        $display("FAIL decode instr=%08h got=%03h want=%03h (RegSrc,RegWrite,ImmSrc,ALUSrc,ALUControl,MemWrite,MemtoReg,PCSrc)",
                 e.ins, got, e.exp);
      end
    end
  end

  initial begin
    logic [31:0] ins;
    reset = 1'b0; Instr = 32'h0; ALUFlags = 4'h0; mflags = 4'h0;
    @(posedge clk); #1;
    // Decode during reset: AL decodes normally, EQ sees zero flags
    apply(32'hE0810002, 4'h0);
    apply(32'h0A000000, 4'hF);
    apply(32'hE0510002, 4'h4);   // SUBS during reset must not set flags
    apply(32'h0A000000, 4'h0);
    reset = 1'b1;
    apply(32'hE0810002, 4'h0);
    apply(32'hE5912000, 4'h0);
    apply(32'hE5812000, 4'h0);
    apply(32'hEAFFFFFE, 4'h0);
    apply(32'hE081F002, 4'h0);
    apply(32'hE0510002, 4'h4);
    apply(32'h0A000000, 4'h0);
    apply(32'h1A000000, 4'h0);
    apply(32'h00810002, 4'h0);
    // Async reset between edges clears Z immediately
    reset = 1'b0; #1; mflags = 4'h0;
    apply(32'h00810002, 4'h0);
    reset = 1'b1;
    apply(32'hE1510002, 4'h6);
    apply(32'h0A000000, 4'h0);
    apply(32'h2A000000, 4'h0);
    apply(32'hF0810002, 4'h0);   // NV suppresses everything gated
    for (int i = 0; i < 1500; i++) begin
      ins = $urandom;
      if ($urandom_range(0, 7) < 3) ins[31:28] = 4'hE;
      if ($urandom_range(0, 3) == 0) ins[15:12] = 4'hF;
      if (ins[27:26] == 2'b00 && $urandom_range(0, 1) == 1) begin
        case ($urandom_range(0, 4))
          0: ins[24:21] = 4'd4;
          1: ins[24:21] = 4'd2;
          2: ins[24:21] = 4'd0;
          3: ins[24:21] = 4'd12;
          default: ins[24:21] = 4'd10;
        endcase
      end
      if ($urandom_range(0, 63) == 0) begin
        reset = 1'b0; #1; mflags = 4'h0; #1; reset = 1'b1;
      end
      apply(ins, 4'($urandom));
    end
    repeat (3) @(negedge clk);
    if (sbq.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, want 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
